// File: rtl/store_buffer.sv
// Store buffer between EX/MEM and data memory: queues stores, forwards to loads.
// Ports: clk, rst (async low), req_* in, stall/ld_* out, memory address/wrtData/strobes, readData in.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        stall,
  output logic        ld_valid,
  output logic [15:0] ld_data,
  output logic        sb_empty,
  output logic [15:0] address,
  output logic [15:0] wrtData,
  output logic        MemRead,
  output logic        MemWrt,
  input  logic [15:0] readData
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t FULL = cnt_t'(DEPTH);

  logic [15:0] addr_q [DEPTH];
  logic [15:0] data_q [DEPTH];

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;

  logic        ldv_q, ldv_d;
  logic        hit_q;
  logic [15:0] fwd_q;
  logic [15:0] last_q;

  logic        is_st, is_ld;
  logic        full, nonempty;
  logic        hit, miss;
  logic [15:0] hit_data;
  logic        enq, deq;
  ptr_t        idx;

  assign is_st    = req_valid & req_write;
  assign is_ld    = req_valid & ~req_write;
  assign full     = (count_q == FULL);
  assign nonempty = (count_q != '0);
  assign sb_empty = ~nonempty;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + ptr_t'(i);
      if ((cnt_t'(i) < count_q) && (addr_q[idx] == req_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  assign miss    = is_ld & ~hit;
  assign MemRead = miss & ~full;
  assign MemWrt  = nonempty & ~MemRead;
  assign stall   = full & (is_st | miss);
  assign enq     = is_st & ~full;
  assign deq     = MemWrt;
  assign ldv_d   = is_ld & ~stall;

  always_comb begin
    address = '0;
    wrtData = '0;
    if (nonempty) begin
      address = addr_q[head_q];
      wrtData = data_q[head_q];
    end
    if (MemRead) address = req_addr;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) tail_d = tail_q + ptr_t'(1);
    if (deq) head_d = head_q + ptr_t'(1);
    count_d = count_q + cnt_t'(enq) - cnt_t'(deq);
  end

  // Miss data arrives from memory the cycle after MemRead.
  assign ld_valid = ldv_q;
  assign ld_data  = ldv_q ? (hit_q ? fwd_q : readData) : last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ldv_q   <= 1'b0;
      hit_q   <= 1'b0;
      fwd_q   <= '0;
      last_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ldv_q   <= ldv_d;
      hit_q   <= hit;
      if (ldv_d) fwd_q <= hit_data;
      if (ldv_q) last_q <= ld_data;
      if (enq) begin
        addr_q[tail_q] <= req_addr;
        data_q[tail_q] <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model plus directed vectors.
// Memory is modelled here with a one-cycle registered read.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [15:0] readData = '0;
  logic        stall, ld_valid, sb_empty, MemRead, MemWrt;
  logic [15:0] ld_data, address, wrtData;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data),
    .sb_empty(sb_empty), .address(address), .wrtData(wrtData),
    .MemRead(MemRead), .MemWrt(MemWrt), .readData(readData)
  );

  logic [15:0] mem [256];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h2BCD ^ 16'(i);
  end

  always @(posedge clk) begin
    if (MemWrt) mem[address[7:0]] <= wrtData;
    if (MemRead) readData <= mem[address[7:0]];
  end

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pending stores in program order; a load sees the youngest
  // pending store to its address, else what memory holds.
  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } ent_t;

  ent_t        q[$];
  logic        pend_v = 1'b0;
  logic [15:0] pend_d = '0;
  logic [15:0] last_d = '0;
  logic        m_stall = 1'b0;

  always @(negedge clk) begin
    logic        ld, st, full, hit, e_mr, e_mw;
    logic [15:0] hd, e_addr, e_wd;
    if (!rst) begin
      q.delete();
      pend_v  = 1'b0;
      pend_d  = '0;
      last_d  = '0;
      m_stall = 1'b0;
      chk("rst_stall", 16'(stall), 16'd0);
      chk("rst_memread", 16'(MemRead), 16'd0);
      chk("rst_memwrt", 16'(MemWrt), 16'd0);
      chk("rst_empty", 16'(sb_empty), 16'd1);
      chk("rst_addr", address, 16'h0);
      chk("rst_wdata", wrtData, 16'h0);
      chk("rst_ldv", 16'(ld_valid), 16'd0);
      chk("rst_ldd", ld_data, 16'h0);
    end else begin
      ld   = req_valid & ~req_write;
      st   = req_valid & req_write;
      full = (q.size() == DEPTH);
      hit  = 1'b0;
      hd   = '0;
      foreach (q[i]) if (q[i].a == req_addr) begin
        hit = 1'b1;
        hd  = q[i].d;
      end
      m_stall = (st && full) || (ld && !hit && full);
      e_mr    = ld && !hit && !full;
      e_mw    = (q.size() > 0) && !e_mr;
      e_addr  = e_mr ? req_addr : (q.size() > 0 ? q[0].a : 16'h0);
      e_wd    = (q.size() > 0) ? q[0].d : 16'h0;
      chk("stall", 16'(stall), 16'(m_stall));
      chk("memread", 16'(MemRead), 16'(e_mr));
      chk("memwrt", 16'(MemWrt), 16'(e_mw));
      chk("address", address, e_addr);
      chk("wrtdata", wrtData, e_wd);
      chk("sb_empty", 16'(sb_empty), 16'(q.size() == 0));
      chk("ld_valid", 16'(ld_valid), 16'(pend_v));
      chk("ld_data", ld_data, pend_v ? pend_d : last_d);
      if (pend_v) last_d = pend_d;
      pend_v = ld && !m_stall;
      if (pend_v) pend_d = hit ? hd : mem[req_addr[7:0]];
      if (e_mw) void'(q.pop_front());
      if (st && !full) q.push_back('{a: req_addr, d: req_wdata});
    end
  end

  task automatic cyc(input logic v, input logic w,
                     input logic [15:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic issue(input logic w, input logic [15:0] a,
                       input logic [15:0] d);
    int tries;
    tries = 0;
    do begin
      cyc(1'b1, w, a, d);
      tries++;
    end while (m_stall && tries < 16);
    chk("hold_timeout", 16'(m_stall), 16'd0);
  endtask

  initial begin
    #1 rst = 1'b0;
    idle();
    idle();
    chk("init_empty", 16'(sb_empty), 16'd1);
    chk("init_addr", address, 16'h0);
    @(posedge clk);
    #1 rst = 1'b1;

    // miss on untouched memory
    cyc(1'b1, 1'b0, 16'h0000, 16'h0);
    chk("l0_memread", 16'(MemRead), 16'd1);
    chk("l0_addr", address, 16'h0000);
    idle();
    chk("l0_ldv", 16'(ld_valid), 16'd1);
    chk("l0_ldd", ld_data, 16'h2BCD);

    // single store drains when idle
    cyc(1'b1, 1'b1, 16'h0004, 16'hAAAA);
    chk("s4_nowrt", 16'(MemWrt), 16'd0);
    idle();
    chk("s4_wrt", 16'(MemWrt), 16'd1);
    chk("s4_addr", address, 16'h0004);
    chk("s4_data", wrtData, 16'hAAAA);
    idle();
    chk("s4_empty", 16'(sb_empty), 16'd1);

    // two stores to one address, then a forwarding load
    cyc(1'b1, 1'b1, 16'h0002, 16'h1111);
    cyc(1'b1, 1'b1, 16'h0002, 16'h2222);
    chk("s2_drain_d", wrtData, 16'h1111);
    cyc(1'b1, 1'b0, 16'h0002, 16'h0);
    chk("l2_nord", 16'(MemRead), 16'd0);
    chk("l2_headwrt", 16'(MemWrt), 16'd1);
    chk("l2_headd", wrtData, 16'h2222);
    idle();
    chk("l2_ldv", 16'(ld_valid), 16'd1);
    chk("l2_ldd", ld_data, 16'h2222);

    // back-to-back misses, then hold
    cyc(1'b1, 1'b0, 16'h0030, 16'h0);
    cyc(1'b1, 1'b0, 16'h0031, 16'h0);
    chk("l30_ldd", ld_data, 16'h2BFD);
    idle();
    chk("l31_ldv", 16'(ld_valid), 16'd1);
    chk("l31_ldd", ld_data, 16'h2BFC);
    idle();
    chk("hold_ldv", 16'(ld_valid), 16'd0);
    chk("hold_ldd", ld_data, 16'h2BFC);

    // drained store visible through memory
    cyc(1'b1, 1'b1, 16'h0040, 16'h1234);
    idle();
    cyc(1'b1, 1'b0, 16'h0040, 16'h0);
    chk("l40_memread", 16'(MemRead), 16'd1);
    idle();
    chk("l40_ldd", ld_data, 16'h1234);

    // consecutive stores, then a miss that starves the drain
    for (int k = 0; k < 5; k++) begin
      issue(1'b1, 16'h0010 + 16'(k), 16'h0100 + 16'(k));
      if (k > 0) chk("burst_addr", address, 16'h000F + 16'(k));
    end
    cyc(1'b1, 1'b0, 16'h0050, 16'h0);
    chk("starve_wrt", 16'(MemWrt), 16'd0);
    issue(1'b1, 16'h0015, 16'h0115);
    chk("resume_addr", address, 16'h0014);
    chk("l50_ldd", ld_data, 16'h2B9D);
    idle();

    // reset mid-operation with a store pending and a load in flight
    cyc(1'b1, 1'b1, 16'h0060, 16'h6666);
    cyc(1'b1, 1'b0, 16'h0061, 16'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_empty", 16'(sb_empty), 16'd1);
    chk("mid_ldv", 16'(ld_valid), 16'd0);
    idle();
    @(posedge clk);
    #1 rst = 1'b1;
    idle();
    chk("post_wrt", 16'(MemWrt), 16'd0);
    idle();
    cyc(1'b1, 1'b0, 16'h0060, 16'h0);
    idle();
    chk("l60_ldd", ld_data, 16'h2BAD);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of pending-store entries (power of two, 2..8).
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have req_valid  input  1  memory request from EX/MEM this cycle.
REQ-005 SHALL have req_write  input  1  1 = store, 0 = load; valid only with req_valid.
REQ-006 SHALL have req_addr  input  16  request address.
REQ-007 SHALL have req_wdata  input  16  store data.
REQ-008 SHALL have stall  output  1  request not accepted this cycle; requester holds the request.
REQ-009 SHALL have ld_valid  output  1  load result valid, exactly one cycle after load acceptance.
REQ-010 SHALL have ld_data  output  16  load result.
REQ-011 SHALL have sb_empty  output  1  no pending stores.
REQ-012 SHALL have address  output  16  data memory address.
REQ-013 SHALL have wrtData  output  16  data memory write data.
REQ-014 SHALL have MemRead  output  1  data memory read strobe.
REQ-015 SHALL have MemWrt  output  1  data memory write strobe.
REQ-016 SHALL have readData  input  16  data memory read result, registered by memory on the edge that sampled MemRead.

Function
REQ-017 SHALL hold stores in a DEPTH-entry FIFO (addr, data), with head/tail pointers wrapping modulo DEPTH and a count of 0..DEPTH.
REQ-018 Store accept: req_valid & req_write & count<DEPTH -> enqueue at tail on edge; stall=0.
REQ-019 Store with count==DEPTH -> stall=1, no enqueue, even if a drain occurs the same cycle.
REQ-020 Load hit: youngest entry with addr==req_addr (combinational search of pre-edge contents) -> its data registered; next cycle ld_valid=1, ld_data=that data; MemRead=0.
REQ-021 Load miss, count<DEPTH -> MemRead=1, address=req_addr this cycle; next cycle ld_valid=1, ld_data=readData.
REQ-022 Load miss with count==DEPTH -> stall=1, no MemRead; drain proceeds; the load is retried by the held request.
REQ-023 Drain: when count>0 and MemRead is not asserted this cycle -> MemWrt=1, address/wrtData=head entry; head pops on edge.
REQ-024 MemRead and MemWrt SHALL never both be 1 in the same cycle.
REQ-025 Simultaneous accepted store and drain -> count unchanged; pointers both advance.
REQ-026 A load hit on the head entry being drained in the same cycle SHALL still forward that entry's data.
REQ-027 Loads SHALL be accepted back-to-back every cycle; throughput 1 per cycle, latency 1.
REQ-028 ld_valid SHALL be 0 in any cycle not following an accepted load; ld_data holds its last value.
REQ-029 With nothing to issue, address/wrtData = head entry (or 0 when empty); strobes 0.
REQ-030 sb_empty = (count==0).

Reset
REQ-031 rst low SHALL immediately clear count, head, tail, ld_valid, ld_data and the hit/forward registers; all pending stores are discarded.
REQ-032 During and after reset until a request arrives: stall=0, MemRead=0, MemWrt=0, sb_empty=1, address=0, wrtData=0.
REQ-033 rst asserted mid-operation SHALL abort any pending load result (no ld_valid after reset release).

Verification
REQ-034 Store 0x0004<-0xAAAA, idle -> next cycle MemWrt=1, address=0x0004, wrtData=0xAAAA; then sb_empty=1.
REQ-035 Five stores in consecutive cycles while loads (misses) starve drain -> fifth stalls; the drain then runs, and the fifth is accepted the cycle after count drops to 3.
REQ-036 Stores 0x0002<-0x1111 then 0x0002<-0x2222 held, load 0x0002 -> next cycle ld_valid=1, ld_data=0x2222, no MemRead.
REQ-037 Load 0x0000 miss after memory reset -> MemRead=1, address=0; next cycle ld_data=0x2BCD, ld_valid=1.
REQ-038 Buffer full, load miss 0x0006 -> stall=1, MemWrt=1 the same cycle; load accepted the next cycle with MemRead=1.
REQ-039 rst pulsed low with 3 pending stores -> sb_empty=1 immediately; no MemWrt after release.
